// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU: single-cycle logic/arith ops, iterative shift-add MULU and restoring DIVU.
// Optional iterative divider is compiled only when ALU_DIVIDER_EN is defined.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
`ifdef ALU_DIVIDER_EN
  localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

  typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [CW-1:0]    cnt;
  logic             last;

  logic [WIDTH-1:0] sum, dif;
  logic [WIDTH-1:0] res_lo, res_hi;
  logic             res_ovf;
  logic             is_mul;
  logic             go_exec;

  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] iter_hi, iter_lo;

`ifdef ALU_DIVIDER_EN
  logic             div_r;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic             ge;
`endif

  // Single-cycle result path, evaluated on the operands present at the accepting edge
  always_comb begin
    sum     = a + b;
    dif     = a - b;
    res_lo  = '0;
    res_hi  = '0;
    res_ovf = 1'b0;
    case (select)
      OP_AND:  res_lo = a & b;
      OP_OR:   res_lo = a | b;
      OP_XOR:  res_lo = a ^ b;
      OP_NOR:  res_lo = ~(a | b);
      OP_ADD: begin
        res_lo  = sum;
        res_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo  = dif;
        res_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  res_lo = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_lo = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_DIVIDER_EN
      OP_DIVU: begin
        if (b == '0) begin
          res_lo = '1;
          res_hi = a;
        end
      end
`endif
      default: begin
        res_lo  = '0;
        res_hi  = '0;
        res_ovf = 1'b0;
      end
    endcase
  end

  assign is_mul = (select == OP_MULU);
`ifdef ALU_DIVIDER_EN
  assign go_exec = is_mul || ((select == OP_DIVU) && (b != '0));
`else
  assign go_exec = is_mul;
`endif

  // One shift-add step: conditional add into the high half, then shift the pair right
  always_comb begin
    msum    = {1'b0, work_hi} + (work_lo[0] ? {1'b0, m} : '0);
    iter_hi = msum[WIDTH:1];
    iter_lo = {msum[0], work_lo[WIDTH-1:1]};
`ifdef ALU_DIVIDER_EN
    shifted = {work_hi, work_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, m});
    trial   = shifted[WIDTH-1:0] - m;
    if (div_r) begin
      iter_hi = ge ? trial : shifted[WIDTH-1:0];
      iter_lo = {work_lo[WIDTH-2:0], ge};
    end
`endif
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = go_exec ? EXEC : FIN;
      EXEC:    if (last) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  // Result registers only change at completion, so iteration values never reach out/hi
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m       <= '0;
      work_hi <= '0;
      work_lo <= '0;
      cnt     <= '0;
      out     <= '0;
      hi      <= '0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
`ifdef ALU_DIVIDER_EN
      div_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work_hi <= '0;
            cnt     <= '0;
`ifdef ALU_DIVIDER_EN
            m       <= is_mul ? a : b;
            work_lo <= is_mul ? b : a;
            div_r   <= !is_mul;
`else
            m       <= a;
            work_lo <= b;
`endif
            if (!go_exec) begin
              out  <= res_lo;
              hi   <= res_hi;
              ovf  <= res_ovf;
              zero <= (res_lo == '0);
            end
          end
        end
        EXEC: begin
          work_hi <= iter_hi;
          work_lo <= iter_lo;
          cnt     <= cnt + CW'(1);
          if (last) begin
            out  <= iter_lo;
            hi   <= iter_hi;
            ovf  <= 1'b0;
            zero <= (iter_lo == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle (WIDTH=32), directed corner cases plus random ops.
// Divider expectations follow ALU_DIVIDER_EN.
module tb_alu_multicycle;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [3:0]   select;
  logic         busy, done, zero, ovf;
  logic [W-1:0] out, hi;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .select(select),
    .busy(busy), .done(done), .out(out), .hi(hi), .zero(zero), .ovf(ovf)
  );

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    int           lat;
    longint       acc;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  logic [W-1:0] prev_out = '0;
  logic [W-1:0] prev_hi  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference behaviour from plain arithmetic on the operation definitions
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic signed [63:0] sx, sy, s;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    e.out = '0; e.hi = '0; e.ovf = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      4'd0: e.out = x & y;
      4'd1: e.out = x | y;
      4'd4: e.out = x ^ y;
      4'd5: e.out = ~(x | y);
      4'd2: begin
        s = sx + sy; e.out = s[W-1:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        s = sx - sy; e.out = s[W-1:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: e.out = (sx < sy) ? 32'd1 : 32'd0;
      4'd3: e.out = (x < y) ? 32'd1 : 32'd0;
      4'd8: begin
        p = {32'd0, x} * {32'd0, y};
        e.out = p[31:0]; e.hi = p[63:32]; e.lat = W + 1;
      end
`ifdef ALU_DIVIDER_EN
      4'd9: begin
        if (y == 0) begin
          e.out = '1; e.hi = x;
        end else begin
          e.out = x / y; e.hi = x % y; e.lat = W + 1;
        end
      end
`endif
      default: begin
        e.out = '0;
      end
    endcase
    e.zero = (e.out == 0);
    return e;
  endfunction

  // Monitor: pops one expectation per DONE, and insists results never move outside DONE
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("out", out, mon_e.out);
          chk("hi", hi, mon_e.hi);
          chk("zero", zero, mon_e.zero);
          chk("ovf", ovf, mon_e.ovf);
          chk("latency", cyc - mon_e.acc + 1, mon_e.lat);
        end
      end else begin
        chk("result_hold", {out, hi}, {prev_out, prev_hi});
      end
    end
    prev_out = out;
    prev_hi  = hi;
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input bit noisy);
    exp_t e;
    int   n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
    select = op; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(op, x, y);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (noisy) begin
        start  = 1'($urandom_range(0, 1));
        a      = $urandom;
        b      = $urandom;
        select = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("busy_timeout", 1, 0);
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7fff_ffff;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] ops [12];
    exp_t       e;
    int         n;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15};
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; select = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", out, 0);
    chk("rst_hi", hi, 0);
    chk("rst_zero", zero, 1);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(4'd2, 32'h7fff_ffff, 32'd1, 1'b0);
    issue(4'd6, 32'd5, 32'd5, 1'b0);
    issue(4'd7, 32'hffff_ffff, 32'd1, 1'b0);
    issue(4'd3, 32'hffff_ffff, 32'd1, 1'b0);
    issue(4'd8, 32'hffff_ffff, 32'hffff_ffff, 1'b1);
    issue(4'd9, 32'd100, 32'd7, 1'b1);
    issue(4'd9, 32'd100, 32'd0, 1'b0);
    issue(4'd6, 32'h8000_0000, 32'd1, 1'b0);
    issue(4'd8, 32'd0, 32'd12345, 1'b0);

    // Reset in the middle of a multiply: nothing may complete
    select = 4'd8; a = $urandom; b = $urandom; start = 1'b1;
    @(posedge clk);
    #1;
    e = model(4'd8, a, b);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("busy_mid_mul", busy, 1);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", out, 0);
    chk("abort_hi", hi, 0);
    chk("abort_zero", zero, 1);
    chk("abort_ovf", ovf, 0);
    repeat (3) begin
      @(negedge clk);
      chk("done_in_reset", done, 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(4'd0, 32'h0000_f0f0, 32'h0000_ff00, 1'b0);

    for (int i = 0; i < 60; i++) begin
      issue(ops[$urandom_range(0, 11)], rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; WIDTH >= 4.
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port START  in  1  operation request; sampled only while BUSY=0.
REQ-005 SHALL have ports A, B  in  WIDTH  operands, captured on accepted START.
REQ-006 SHALL have port SELECT  in  4  operation code, captured on accepted START.
REQ-007 SHALL have port BUSY  out  1  high while an operation is in progress.
REQ-008 SHALL have port DONE  out  1  single-cycle pulse when results become valid.
REQ-009 SHALL have port OUT  out  WIDTH  primary result (low product / quotient).
REQ-010 SHALL have port HI  out  WIDTH  secondary result (high product / remainder), 0 for other ops.
REQ-011 SHALL have port ZERO  out  1  registered, high when OUT == 0.
REQ-012 SHALL have port OVF  out  1  registered signed overflow for ADD/SUB, 0 otherwise.

Function
REQ-013 SHALL decode SELECT: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 0011 SLTU, 0100 XOR, 0101 NOR, 1000 MULU, 1001 DIVU; all other codes give OUT=0, HI=0, OVF=0.
REQ-014 SHALL implement FSM states IDLE, EXEC, FIN; reset state IDLE.
REQ-015 SHALL in IDLE with START=1 capture A, B, SELECT; single-cycle ops go to FIN, MULU/DIVU go to EXEC.
REQ-016 SHALL for single-cycle ops register OUT/HI/ZERO/OVF and assert DONE one cycle after the accepting edge (latency 1).
REQ-017 SHALL compute MULU as unsigned shift-add, one bit per cycle, WIDTH iterations in EXEC; {HI,OUT} = 2*WIDTH-bit product; DONE asserted WIDTH+1 cycles after accept.
REQ-018 SHALL compute DIVU as restoring division, one bit per cycle, WIDTH iterations; OUT = quotient, HI = remainder; DONE WIDTH+1 cycles after accept.
REQ-019 SHALL on DIVU with B=0 skip EXEC: OUT = all ones, HI = A, DONE after 1 cycle.
REQ-020 SHALL hold BUSY=1 from the cycle after accept through the DONE cycle inclusive; FIN returns to IDLE on the next edge.
REQ-021 SHALL ignore START while BUSY=1; operands and SELECT changes during BUSY SHALL not affect the result.
REQ-022 SHALL hold OUT, HI, ZERO, OVF stable from DONE until the next accepted START completes; intermediate iteration values SHALL not appear on OUT/HI.
REQ-023 SHALL accept a new START in the cycle after FIN (back-to-back throughput one op per latency+1 cycles).
REQ-024 SHALL compute ADD/SUB modulo 2^WIDTH; OVF = signed overflow of that operation; SLT/SLTU give OUT = 1 or 0 zero-extended.

Reset
REQ-025 SHALL on RST_N=0, asynchronously and regardless of state, force state IDLE, BUSY=0, DONE=0, OUT=0, HI=0, OVF=0, ZERO=1.
REQ-026 SHALL abort any in-progress operation on reset with no DONE pulse; first START after deassertion SHALL behave as from power-up.

Configuration
REQ-027 SHALL compile the iterative divider only when macro ALU_DIVIDER_EN is defined.
REQ-028 SHALL without ALU_DIVIDER_EN treat SELECT=1001 as an undefined code (OUT=0, HI=0, ZERO=1, latency 1) and contain no divider logic.

Verification (WIDTH=32)
REQ-029 SHALL verify ADD A=0x7FFFFFFF B=1 -> DONE 1 cycle after accept, OUT=0x80000000, OVF=1, ZERO=0.
REQ-030 SHALL verify SUB A=5 B=5 -> OUT=0, ZERO=1, OVF=0; SLT A=0xFFFFFFFF B=1 -> OUT=1; SLTU same operands -> OUT=0.
REQ-031 SHALL verify MULU A=0xFFFFFFFF B=0xFFFFFFFF -> DONE exactly 33 cycles after accept, HI=0xFFFFFFFE, OUT=0x00000001; START pulses during BUSY ignored.
REQ-032 SHALL verify DIVU A=100 B=7 (macro defined) -> 33-cycle latency, OUT=14, HI=2; B=0 -> 1-cycle latency, OUT=0xFFFFFFFF, HI=100.
REQ-033 SHALL verify RST_N low at cycle 10 of a MULU -> BUSY=0, OUT=0, ZERO=1 immediately, no DONE; subsequent AND A=0xF0F0 B=0xFF00 -> OUT=0xF000.
REQ-034 SHALL verify without ALU_DIVIDER_EN: SELECT=1001 A=100 B=7 -> DONE after 1 cycle, OUT=0, HI=0, ZERO=1.
